// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: passes ALU ops straight to MEM/WB and runs a
// request/busy/done handshake for loads/stores, stalling upstream until it completes.
module mem_access_ctrl #(
   parameter int TIMEOUT = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic [15:0] aluOutput_in,
   input  logic [15:0] writeData_in,
   input  logic        RegWrite_in,
   input  logic        MemToReg_in,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic        mem_busy,
   input  logic [15:0] mem_rdata,
   input  logic        mem_done,
   output logic [15:0] aluOutput_out,
   output logic [15:0] readData_out,
   output logic        RegWrite_out,
   output logic        MemToReg_out,
   output logic        valid_out,
   output logic        stall_out,
   output logic        err_out,
   output logic [1:0]  state_dbg
);

   // Handshake: a request is accepted in the first REQ cycle with mem_busy=0;
   // completion is the single-cycle mem_done pulse seen in WAIT.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic [15:0] addr_q, wdata_q;
   logic        access, misaligned;

   assign access     = valid_in & (MemRead_in | MemWrite_in);
   assign misaligned = access & aluOutput_in[0];

   assign aluOutput_out = aluOutput_in;
   assign RegWrite_out  = RegWrite_in;
   assign MemToReg_out  = MemToReg_in;
   assign state_dbg     = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 8'd0;
         addr_q  <= 16'd0;
         wdata_q <= 16'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == REQ) begin
            addr_q  <= aluOutput_in;
            wdata_q <= writeData_in;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      mem_addr     = aluOutput_in;
      mem_wdata    = writeData_in;
      stall_out    = 1'b0;
      valid_out    = 1'b0;
      err_out      = 1'b0;
      readData_out = 16'd0;
      case (state)
         IDLE: begin
            if (misaligned) begin
               state_nxt = ERR;
               stall_out = 1'b1;
            end else if (access) begin
               state_nxt = REQ;
               stall_out = 1'b1;
            end else begin
               valid_out = valid_in;
            end
         end
         REQ: begin
            mem_rd    = MemRead_in;
            mem_wr    = MemWrite_in;
            stall_out = 1'b1;
            if (!mem_busy) begin
               state_nxt = WAIT;
               cnt_nxt   = 8'd0;
            end
         end
         WAIT: begin
            // Address/data stay on the bus as captured at acceptance.
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            if (mem_done) begin
               state_nxt    = IDLE;
               valid_out    = 1'b1;
               readData_out = MemRead_in ? mem_rdata : 16'd0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ERR;
               stall_out = 1'b1;
            end else begin
               cnt_nxt   = cnt + 8'd1;
               stall_out = 1'b1;
            end
         end
         ERR: begin
            err_out   = 1'b1;
            stall_out = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      // Reset silences every strobe and pipeline control immediately.
      if (rst) begin
         mem_rd       = 1'b0;
         mem_wr       = 1'b0;
         stall_out    = 1'b0;
         valid_out    = 1'b0;
         err_out      = 1'b0;
         readData_out = 16'd0;
      end
   end

endmodule
